cp_dma_engine: RTL and testbench
================================

Name: cp_dma_engine

Overview:
- Parametrised DMA/control front-end for the crypto coprocessor; next generation of the CP2 register/DMA shell.
- CPU programs the key, source and destination addresses, length and mode through a word register file.
- The engine moves data through the cipher core block by block under HOLD/HOLD_ACK bus arbitration, then raises INT.
- New versus CP2: multi-block transfers, separate destination address, length checking, and stall on loss of grant.

Parameters:
- ADDR_W, 20, DMA byte-address width.
- DATA_W, 32, bus word width.
- BLK_WORDS, 4, words per cipher block (block = BLK_WORDS*DATA_W bits).
- KEY_WORDS, 8, key register words (max 256-bit key).
- LEN_W, 16, length field width, counted in words.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- we_cpu  in  1  CPU register write strobe.
- addr_cpu  in  6  CPU register word index.
- wrData_cpu  in  DATA_W  CPU write data.
- rdData_cpu  out  DATA_W  CPU read data, combinational from addr_cpu.
- HOLD  out  1  bus request.
- HOLD_ACK  in  1  bus grant.
- we_dma  out  1  memory write strobe.
- addr_dma  out  ADDR_W  memory byte address.
- wrData_dma  in  DATA_W  memory read data into the engine (combinational memory).
- rdData_dma  out  DATA_W  data from the engine to memory.
- INT  out  1  completion interrupt, level.
- core_start  out  1  one-cycle start pulse to the cipher core.
- core_encode, core_bits  out  1 each  mode to the core (bits=1: 256-bit key, 0: 128-bit key).
- core_key  out  KEY_WORDS*DATA_W  key; reg 2 maps to the MSW.
- core_din  out  BLK_WORDS*DATA_W  block to the core.
- core_dout  in  BLK_WORDS*DATA_W  result from the core.
- core_done  in  1  result-valid pulse.

Behaviour:
- Register map:
  - 0: ctrl/status. Bit31 busy (RO), bit30 go (write-1 starts, self-clears), bit29 bits, bit28 encode, bit27 err (RO), bit26 int_pend (RO), [LEN_W-1:0] length.
  - 1: src.
  - 2..2+KEY_WORDS-1: key.
  - 0x0A: dst.
  - 0x0B: perf (optional feature).
  - Other addresses read 0.
- Reset (rst=0 at clk edge): state IDLE.
  - All registers 0.
  - HOLD, we_dma, INT, core_start all 0; addr_dma=0; rdData_dma=0.
  - Reset mid-transfer aborts immediately; there is no writeback.
- Writes while busy are ignored.
- Write to reg 0 with go=0 clears int_pend and err.
- Write with go=1 clears them and starts.
- Start checks:
  - length==0: no bus activity; INT=1 on the next cycle.
  - length%BLK_WORDS!=0: err=1 and INT=1 on the next cycle; no bus activity.
- Otherwise capture cur_src=src, cur_dst=dst, remaining=length.
- FSM:
  - IDLE.
  - REQ_RD: HOLD=1 the cycle after the go write; wait for HOLD_ACK.
  - RD: BLK_WORDS cycles; word k: addr_dma=cur_src+4k, wrData_dma sampled into block word k (word 0 = bits [DATA_W-1:0]).
  - REL_RD: HOLD=0; wait for HOLD_ACK=0.
  - CORE: core_start=1 for one cycle, then wait for core_done; latch core_dout.
  - REQ_WR: HOLD=1; wait for HOLD_ACK.
  - WR: we_dma=1 for BLK_WORDS cycles; addr_dma=cur_dst+4k; rdData_dma=result word k.
  - REL_WR: HOLD=0; wait for HOLD_ACK=0; cur_src+=4*BLK_WORDS, cur_dst+=4*BLK_WORDS, remaining-=BLK_WORDS.
  - Then REQ_RD if remaining!=0, else DONE.
  - DONE: int_pend=1 (INT) for one cycle, then IDLE.
- HOLD_ACK deasserted during RD/WR: stall; hold the word index, force we_dma=0; resume when re-granted.
- Address arithmetic wraps modulo 2^ADDR_W.
- Mode and key are sampled at go; later register writes do not affect the transfer in flight.

Optional Feature:
- CP_DMA_PERF_CNT_EN defined:
  - reg 0x0B is a DATA_W cycle counter, cleared at go and incremented every busy cycle.
  - It freezes at DONE and saturates at all-ones.
- Undefined: reg 0x0B reads 0 and no counter logic exists.

Decomposition:
- Package cp_dma_pkg holds the FSM state enum, register index constants (REG_CTRL, REG_SRC, REG_KEY0, REG_DST, REG_PERF) and ctrl bit positions.
- One sub-module, cp_dma_regs: register file, read mux, go/INT-clear decode.
- Top level holds the FSM, counters and block buffers.

Test Plan:
- Key all-F (bits=1), src=400, dst=400, length=4, encode=1, data all-F, loopback core model.
  - HOLD rises 1 cycle after go.
  - Reads at 400/404/408/40C.
  - HOLD drops; core_start pulses once.
  - Writes at 400..40C return core_dout; INT=1; ctrl write 0x2000_0004 clears INT.
- length=12, src=0x800, dst=0x1000.
  - 3 blocks; HOLD released between read and write phases of each block.
  - Final write address 0x102C; exactly 3 core_start pulses.
- length=6: err=1, INT next cycle, HOLD never asserted.
- length=0: INT next cycle, err=0, no bus activity.
- HOLD_ACK dropped for 3 cycles during RD word 2.
  - addr_dma holds src+8; word sequence unchanged.
- rst low in WR word 1: next cycle HOLD=0, we_dma=0, INT=0, status reads 0.
- With CP_DMA_PERF_CNT_EN: reg 0x0B equals the measured go-to-INT cycle count.

Source files
------------

// File: rtl/cp_dma_pkg.sv
// ============================================================================
// cp_dma_pkg : shared FSM states, register indices and ctrl bit positions
// Rev 1.0
// ============================================================================
`default_nettype none

package cp_dma_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_REQ_RD    = 4'd1,
    S_RD        = 4'd2,
    S_REL_RD    = 4'd3,
    S_CORE      = 4'd4,
    S_CORE_WAIT = 4'd5,
    S_REQ_WR    = 4'd6,
    S_WR        = 4'd7,
    S_REL_WR    = 4'd8,
    S_DONE      = 4'd9
  } dma_state_e;

  localparam logic [5:0] REG_CTRL = 6'h00;
  localparam logic [5:0] REG_SRC  = 6'h01;
  localparam logic [5:0] REG_KEY0 = 6'h02;
  localparam logic [5:0] REG_DST  = 6'h0A;
  localparam logic [5:0] REG_PERF = 6'h0B;

  localparam int CTRL_BUSY = 31;
  localparam int CTRL_GO   = 30;
  localparam int CTRL_BITS = 29;
  localparam int CTRL_ENC  = 28;
  localparam int CTRL_ERR  = 27;
  localparam int CTRL_INT  = 26;

endpackage

`default_nettype wire

// File: rtl/cp_dma_regs.sv
// ============================================================================
// cp_dma_regs : CPU register file, read mux, go/interrupt-clear decode
// Rev 1.0   (reg 0x0B readable only with CP_DMA_PERF_CNT_EN)
// ============================================================================
`default_nettype none

module cp_dma_regs
  import cp_dma_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int BLK_WORDS = 4,
  parameter int KEY_WORDS = 8,
  parameter int LEN_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_cpu,
  input  logic [5:0]                  addr_cpu,
  input  logic [DATA_W-1:0]           wrData_cpu,
  output logic [DATA_W-1:0]           rdData_cpu,
  input  logic                        busy,
  input  logic                        set_int,
`ifdef CP_DMA_PERF_CNT_EN
  input  logic [DATA_W-1:0]           perf,
`endif
  output logic                        start,
  output logic [LEN_W-1:0]            start_len,
  output logic                        start_bits,
  output logic                        start_enc,
  output logic [ADDR_W-1:0]           src,
  output logic [ADDR_W-1:0]           dst,
  output logic [KEY_WORDS*DATA_W-1:0] key,
  output logic                        int_pend
);

  localparam logic [LEN_W-1:0] BLK_LEN = LEN_W'(BLK_WORDS);

  logic             wr_en;
  logic             go_wr;
  logic             len_ok;
  logic             err;
  logic             bits;
  logic             encode;
  logic [LEN_W-1:0] length;

  assign wr_en      = we_cpu && !busy;
  assign go_wr      = wr_en && (addr_cpu == REG_CTRL) && wrData_cpu[CTRL_GO];
  assign start_len  = wrData_cpu[LEN_W-1:0];
  assign start_bits = wrData_cpu[CTRL_BITS];
  assign start_enc  = wrData_cpu[CTRL_ENC];
  assign len_ok     = (start_len != '0) && ((start_len % BLK_LEN) == '0);
  assign start      = go_wr && len_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bits     <= 1'b0;
      encode   <= 1'b0;
      length   <= '0;
      err      <= 1'b0;
      int_pend <= 1'b0;
      src      <= '0;
      dst      <= '0;
      key      <= '0;
    end else begin
      if (set_int) int_pend <= 1'b1;
      if (wr_en) begin
        // Any ctrl write clears status; a rejected go reports completion at once.
        if (addr_cpu == REG_CTRL) begin
          bits     <= start_bits;
          encode   <= start_enc;
          length   <= start_len;
          int_pend <= go_wr && !len_ok;
          err      <= go_wr && (start_len != '0) && !len_ok;
        end
        if (addr_cpu == REG_SRC) src <= wrData_cpu[ADDR_W-1:0];
        if (addr_cpu == REG_DST) dst <= wrData_cpu[ADDR_W-1:0];
        for (int i = 0; i < KEY_WORDS; i++) begin
          if (addr_cpu == REG_KEY0 + 6'(i))
            key[(KEY_WORDS-1-i)*DATA_W +: DATA_W] <= wrData_cpu;
        end
      end
    end
  end

  always_comb begin
    rdData_cpu = '0;
    if (addr_cpu == REG_CTRL) begin
      rdData_cpu[CTRL_BUSY]  = busy;
      rdData_cpu[CTRL_BITS]  = bits;
      rdData_cpu[CTRL_ENC]   = encode;
      rdData_cpu[CTRL_ERR]   = err;
      rdData_cpu[CTRL_INT]   = int_pend;
      rdData_cpu[LEN_W-1:0]  = length;
    end else if (addr_cpu == REG_SRC) begin
      rdData_cpu = DATA_W'(src);
    end else if (addr_cpu == REG_DST) begin
      rdData_cpu = DATA_W'(dst);
`ifdef CP_DMA_PERF_CNT_EN
    end else if (addr_cpu == REG_PERF) begin
      rdData_cpu = perf;
`endif
    end
    for (int i = 0; i < KEY_WORDS; i++) begin
      if (addr_cpu == REG_KEY0 + 6'(i))
        rdData_cpu = key[(KEY_WORDS-1-i)*DATA_W +: DATA_W];
    end
  end

endmodule

`default_nettype wire

// File: rtl/cp_dma_engine.sv
// ============================================================================
// cp_dma_engine : block DMA front-end for the cipher core (HOLD/HOLD_ACK bus)
// Rev 1.0   (optional go-to-done cycle counter: CP_DMA_PERF_CNT_EN)
// ============================================================================
`default_nettype none

module cp_dma_engine
  import cp_dma_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int BLK_WORDS = 4,
  parameter int KEY_WORDS = 8,
  parameter int LEN_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_cpu,
  input  logic [5:0]                  addr_cpu,
  input  logic [DATA_W-1:0]           wrData_cpu,
  output logic [DATA_W-1:0]           rdData_cpu,
  output logic                        HOLD,
  input  logic                        HOLD_ACK,
  output logic                        we_dma,
  output logic [ADDR_W-1:0]           addr_dma,
  input  logic [DATA_W-1:0]           wrData_dma,
  output logic [DATA_W-1:0]           rdData_dma,
  output logic                        INT,
  output logic                        core_start,
  output logic                        core_encode,
  output logic                        core_bits,
  output logic [KEY_WORDS*DATA_W-1:0] core_key,
  output logic [BLK_WORDS*DATA_W-1:0] core_din,
  input  logic [BLK_WORDS*DATA_W-1:0] core_dout,
  input  logic                        core_done
);

  localparam int                IDX_W     = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLK_WORDS - 1);
  localparam logic [ADDR_W-1:0] BLK_BYTES = ADDR_W'(4 * BLK_WORDS);
  localparam logic [LEN_W-1:0]  BLK_LEN   = LEN_W'(BLK_WORDS);

  dma_state_e                  state;
  dma_state_e                  state_nxt;
  logic [IDX_W-1:0]            widx;
  logic [ADDR_W-1:0]           cur_src;
  logic [ADDR_W-1:0]           cur_dst;
  logic [LEN_W-1:0]            remaining;
  logic [BLK_WORDS*DATA_W-1:0] blk_in;
  logic [BLK_WORDS*DATA_W-1:0] blk_out;
  logic                        cur_bits;
  logic                        cur_enc;
  logic [KEY_WORDS*DATA_W-1:0] cur_key;

  logic                        busy;
  logic                        set_int;
  logic                        start;
  logic [LEN_W-1:0]            start_len;
  logic                        start_bits;
  logic                        start_enc;
  logic [ADDR_W-1:0]           src;
  logic [ADDR_W-1:0]           dst;
  logic [KEY_WORDS*DATA_W-1:0] key;
  logic                        int_pend;

  assign busy    = (state != S_IDLE);
  assign set_int = (state == S_DONE);

`ifdef CP_DMA_PERF_CNT_EN
  logic [DATA_W-1:0] perf;
  logic              go_wr;

  assign go_wr = we_cpu && !busy && (addr_cpu == REG_CTRL) && wrData_cpu[CTRL_GO];

  // Counts every busy cycle including DONE, so it stops once INT is up.
  always_ff @(posedge clk) begin
    if (!rst)                    perf <= '0;
    else if (go_wr)              perf <= '0;
    else if (busy && perf != '1) perf <= perf + DATA_W'(1);
  end
`endif

  cp_dma_regs #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BLK_WORDS (BLK_WORDS),
    .KEY_WORDS (KEY_WORDS),
    .LEN_W     (LEN_W)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .we_cpu     (we_cpu),
    .addr_cpu   (addr_cpu),
    .wrData_cpu (wrData_cpu),
    .rdData_cpu (rdData_cpu),
    .busy       (busy),
    .set_int    (set_int),
`ifdef CP_DMA_PERF_CNT_EN
    .perf       (perf),
`endif
    .start      (start),
    .start_len  (start_len),
    .start_bits (start_bits),
    .start_enc  (start_enc),
    .src        (src),
    .dst        (dst),
    .key        (key),
    .int_pend   (int_pend)
  );

  assign INT         = int_pend;
  assign core_bits   = cur_bits;
  assign core_encode = cur_enc;
  assign core_key    = cur_key;
  assign core_din    = blk_in;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    HOLD       = 1'b0;
    we_dma     = 1'b0;
    addr_dma   = '0;
    rdData_dma = '0;
    core_start = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_REQ_RD;
      S_REQ_RD: begin
        HOLD = 1'b1;
        if (HOLD_ACK) state_nxt = S_RD;
      end
      S_RD: begin
        HOLD     = 1'b1;
        addr_dma = cur_src + ADDR_W'({widx, 2'b00});
        if (HOLD_ACK && widx == LAST_IDX) state_nxt = S_REL_RD;
      end
      S_REL_RD: if (!HOLD_ACK) state_nxt = S_CORE;
      S_CORE: begin
        core_start = 1'b1;
        state_nxt  = S_CORE_WAIT;
      end
      S_CORE_WAIT: if (core_done) state_nxt = S_REQ_WR;
      S_REQ_WR: begin
        HOLD = 1'b1;
        if (HOLD_ACK) state_nxt = S_WR;
      end
      S_WR: begin
        // Strobe only while granted; the word index freezes across a stall.
        HOLD       = 1'b1;
        we_dma     = HOLD_ACK;
        addr_dma   = cur_dst + ADDR_W'({widx, 2'b00});
        rdData_dma = blk_out[widx*DATA_W +: DATA_W];
        if (HOLD_ACK && widx == LAST_IDX) state_nxt = S_REL_WR;
      end
      S_REL_WR: if (!HOLD_ACK) state_nxt = (remaining == BLK_LEN) ? S_DONE : S_REQ_RD;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      widx      <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      blk_in    <= '0;
      blk_out   <= '0;
      cur_bits  <= 1'b0;
      cur_enc   <= 1'b0;
      cur_key   <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          cur_src   <= src;
          cur_dst   <= dst;
          remaining <= start_len;
          cur_bits  <= start_bits;
          cur_enc   <= start_enc;
          cur_key   <= key;
          widx      <= '0;
        end
        S_RD: if (HOLD_ACK) begin
          blk_in[widx*DATA_W +: DATA_W] <= wrData_dma;
          widx <= (widx == LAST_IDX) ? '0 : widx + IDX_W'(1);
        end
        S_CORE_WAIT: if (core_done) blk_out <= core_dout;
        S_WR: if (HOLD_ACK) widx <= (widx == LAST_IDX) ? '0 : widx + IDX_W'(1);
        S_REL_WR: if (!HOLD_ACK) begin
          cur_src   <= cur_src + BLK_BYTES;
          cur_dst   <= cur_dst + BLK_BYTES;
          remaining <= remaining - BLK_LEN;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cp_dma_engine.sv
// ============================================================================
// tb_cp_dma_engine : scoreboard bench for cp_dma_engine (honours CP_DMA_PERF_CNT_EN)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cp_dma_engine;
  import cp_dma_pkg::*;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int KW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [KW*DW-1:0] key;
    logic [BW*DW-1:0] din;
    logic             bits;
    logic             enc;
  } core_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              we_cpu = 1'b0;
  logic [5:0]        addr_cpu = '0;
  logic [DW-1:0]     wrData_cpu = '0;
  logic [DW-1:0]     rdData_cpu;
  logic              HOLD;
  logic              HOLD_ACK = 1'b0;
  logic              we_dma;
  logic [AW-1:0]     addr_dma;
  logic [DW-1:0]     wrData_dma;
  logic [DW-1:0]     rdData_dma;
  logic              INT;
  logic              core_start;
  logic              core_encode;
  logic              core_bits;
  logic [KW*DW-1:0]  core_key;
  logic [BW*DW-1:0]  core_din;
  logic [BW*DW-1:0]  core_dout = '0;
  logic              core_done = 1'b0;

  int passed = 0;
  int total  = 0;
  int core_starts = 0;
  logic [AW-1:0] last_wr = '0;
  logic          mem_allf = 1'b0;
  logic          stall_armed = 1'b0;
  int            stall_left = 0;
  logic [AW-1:0] stall_addr = '0;
  logic [BW*DW-1:0] mask = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  wr_t   wr_q[$];
  core_t core_q[$];

  cp_dma_engine dut (
    .clk         (clk),
    .rst         (rst),
    .we_cpu      (we_cpu),
    .addr_cpu    (addr_cpu),
    .wrData_cpu  (wrData_cpu),
    .rdData_cpu  (rdData_cpu),
    .HOLD        (HOLD),
    .HOLD_ACK    (HOLD_ACK),
    .we_dma      (we_dma),
    .addr_dma    (addr_dma),
    .wrData_dma  (wrData_dma),
    .rdData_dma  (rdData_dma),
    .INT         (INT),
    .core_start  (core_start),
    .core_encode (core_encode),
    .core_bits   (core_bits),
    .core_key    (core_key),
    .core_din    (core_din),
    .core_dout   (core_dout),
    .core_done   (core_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {12'hC0D, a};
  endfunction

  assign wrData_dma = mem_allf ? 32'hFFFF_FFFF : mem_word(addr_dma);

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cpu_wr(input logic [5:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we_cpu = 1'b1; addr_cpu = a; wrData_cpu = d;
    @(negedge clk);
    we_cpu = 1'b0;
  endtask

  task automatic cpu_rd(input logic [5:0] a, output logic [DW-1:0] v);
    @(negedge clk);
    addr_cpu = a;
    #1 v = rdData_cpu;
  endtask

  task automatic wait_int(input string name, output int n);
    n = 0;
    while (!INT && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, INT, 1'b1);
  endtask

  // Expected core handoffs and memory writes for a transfer (nwr caps the writes).
  task automatic push_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input int nblk,
                           input int nwr, input logic bits, input logic enc,
                           input logic [KW*DW-1:0] key, input logic allf);
    logic [BW*DW-1:0] din;
    logic [AW-1:0]    a;
    core_t            c;
    wr_t              x;
    int               w;
    w = 0;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < BW; k++) begin
        a = s + AW'(16*b + 4*k);
        din[k*DW +: DW] = allf ? 32'hFFFF_FFFF : mem_word(a);
      end
      c.key = key; c.din = din; c.bits = bits; c.enc = enc;
      core_q.push_back(c);
      for (int k = 0; k < BW; k++) begin
        if (w < nwr) begin
          x.addr = d + AW'(16*b + 4*k);
          x.data = din[k*DW +: DW] ^ mask[k*DW +: DW];
          wr_q.push_back(x);
          w++;
        end
      end
    end
  endtask

  // Bus arbiter: grant follows request, with an optional 3-cycle drop on one read address.
  initial begin
    forever begin
      @(negedge clk);
      if (stall_armed && HOLD && HOLD_ACK && !we_dma && addr_dma == stall_addr) begin
        stall_armed = 1'b0;
        stall_left  = 3;
      end
      if (stall_left > 0) begin
        chk("stall_addr_hold", addr_dma, stall_addr);
        chk("stall_no_we", we_dma, 1'b0);
        HOLD_ACK = 1'b0;
        stall_left--;
      end else begin
        HOLD_ACK = HOLD;
      end
    end
  end

  // Cipher core model: two cycles of latency, result = input XOR per-word mask.
  initial begin
    logic [BW*DW-1:0] buf_q;
    int cnt;
    cnt = 0; buf_q = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1;
          core_dout = buf_q;
        end
      end
      if (core_start) begin
        buf_q = core_din ^ mask;
        cnt   = 2;
      end
    end
  end

  // Monitor: compares every write beat and core handoff against the queues.
  initial begin
    wr_t   e;
    core_t c;
    forever begin
      @(posedge clk);
      #8;
      if (we_dma) begin
        if (wr_q.size() == 0) chk("wr_unexpected", we_dma, 1'b0);
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", addr_dma, e.addr);
          chk("wr_data", rdData_dma, e.data);
          last_wr = addr_dma;
        end
      end
      if (core_start) begin
        core_starts++;
        chk("hold_released_at_core", HOLD, 1'b0);
        if (core_q.size() == 0) chk("core_unexpected", core_start, 1'b0);
        else begin
          c = core_q.pop_front();
          chk("core_key", core_key, c.key);
          chk("core_din", core_din, c.din);
          chk("core_bits", core_bits, c.bits);
          chk("core_encode", core_encode, c.enc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] v;
    int n, found, hold_seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hold", HOLD, 1'b0);
    chk("rst_we", we_dma, 1'b0);
    chk("rst_int", INT, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_addr_dma", addr_dma, '0);
    chk("rst_rddata_dma", rdData_dma, '0);
    cpu_rd(REG_CTRL, v);
    chk("rst_ctrl", v, '0);
    @(negedge clk);
    rst = 1'b1;

    // Single block, 256-bit key, encode, all-ones data, src == dst
    for (int i = 0; i < KW; i++) cpu_wr(6'(2 + i), 32'hFFFF_FFFF);
    cpu_wr(REG_SRC, 32'h400);
    cpu_wr(REG_DST, 32'h400);
    cpu_rd(6'h02, v);
    chk("key0_readback", v, 32'hFFFF_FFFF);
    cpu_rd(REG_SRC, v);
    chk("src_readback", v, 32'h400);
    cpu_rd(6'h0C, v);
    chk("unmapped_reads_zero", v, '0);
    mem_allf = 1'b1;
    core_starts = 0;
    push_xfer(20'h400, 20'h400, 1, 4, 1'b1, 1'b1, '1, 1'b1);
    cpu_wr(REG_CTRL, 32'h7000_0004);
    chk("t1_hold_after_go", HOLD, 1'b1);
    wait_int("t1_int", n);
    chk("t1_core_starts", core_starts, 1);
    chk("t1_wr_q_empty", wr_q.size(), 0);
    chk("t1_core_q_empty", core_q.size(), 0);
`ifdef CP_DMA_PERF_CNT_EN
    cpu_rd(REG_PERF, v);
    chk("t1_perf_cycles", v, n);
`else
    cpu_rd(REG_PERF, v);
    chk("t1_perf_absent", v, '0);
`endif
    cpu_rd(REG_CTRL, v);
    chk("t1_status_done", v, 32'h3400_0004);
    cpu_wr(REG_CTRL, 32'h2000_0004);
    chk("t1_int_cleared", INT, 1'b0);
    cpu_rd(REG_CTRL, v);
    chk("t1_status_cleared", v, 32'h2000_0004);
    mem_allf = 1'b0;

    // Three blocks, separate destination
    cpu_wr(REG_SRC, 32'h800);
    cpu_wr(REG_DST, 32'h1000);
    core_starts = 0;
    push_xfer(20'h800, 20'h1000, 3, 12, 1'b0, 1'b0, '1, 1'b0);
    cpu_wr(REG_CTRL, 32'h4000_000C);
    wait_int("t2_int", n);
    chk("t2_core_starts", core_starts, 3);
    chk("t2_last_wr_addr", last_wr, 20'h102C);
    chk("t2_wr_q_empty", wr_q.size(), 0);
    cpu_rd(REG_CTRL, v);
    chk("t2_status_done", v, 32'h0400_000C);
    cpu_wr(REG_CTRL, 32'h0);

    // Misaligned length
    cpu_wr(REG_CTRL, 32'h4000_0006);
    chk("t3_int_next_cycle", INT, 1'b1);
    hold_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (HOLD) hold_seen = 1;
      @(negedge clk);
    end
    chk("t3_no_hold", hold_seen, 0);
    cpu_rd(REG_CTRL, v);
    chk("t3_status_err", v, 32'h0C00_0006);
    cpu_wr(REG_CTRL, 32'h0);
    cpu_rd(REG_CTRL, v);
    chk("t3_err_cleared", v, '0);

    // Zero length
    cpu_wr(REG_CTRL, 32'h4000_0000);
    chk("t4_int_next_cycle", INT, 1'b1);
    chk("t4_no_hold", HOLD, 1'b0);
    cpu_rd(REG_CTRL, v);
    chk("t4_status_no_err", v, 32'h0400_0000);
    cpu_wr(REG_CTRL, 32'h0);

    // Grant dropped for 3 cycles while read word 2 is on the bus
    cpu_wr(REG_SRC, 32'h300);
    cpu_wr(REG_DST, 32'h500);
    push_xfer(20'h300, 20'h500, 1, 4, 1'b0, 1'b1, '1, 1'b0);
    stall_addr  = 20'h308;
    stall_armed = 1'b1;
    cpu_wr(REG_CTRL, 32'h5000_0004);
    wait_int("t5_int", n);
    chk("t5_stall_happened", stall_armed, 1'b0);
    chk("t5_wr_q_empty", wr_q.size(), 0);
    cpu_wr(REG_CTRL, 32'h0);

    // Reset while write word 1 is on the bus
    cpu_wr(REG_SRC, 32'h600);
    cpu_wr(REG_DST, 32'h700);
    push_xfer(20'h600, 20'h700, 1, 2, 1'b0, 1'b0, '1, 1'b0);
    cpu_wr(REG_CTRL, 32'h4000_0004);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      #1;
      if (we_dma && addr_dma == 20'h704) found = 1;
    end
    chk("t6_reached_wr1", found, 1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_hold", HOLD, 1'b0);
    chk("t6_we", we_dma, 1'b0);
    chk("t6_int", INT, 1'b0);
    cpu_rd(REG_CTRL, v);
    chk("t6_status", v, '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_wr_q_empty", wr_q.size(), 0);
    chk("t6_core_q_empty", core_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
